// File: rtl/datapath_mc.sv
// Multicycle core datapath: register file, ALU, and a memory-access sequencer with an MDR.
// Optional macro DATAPATH_MISALIGN_CHECK_EN suppresses misaligned requests and pulses sts_misaligned.
module datapath_mc #(
   parameter  int XLEN  = 32,
   parameter  int NREGS = 32,
   localparam int RA_W  = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [RA_W-1:0] ctl_rs1,
   input  logic [RA_W-1:0] ctl_rs2,
   input  logic [RA_W-1:0] ctl_rd,
   input  logic            ctl_rf_we,
   input  logic [1:0]      ctl_rf_d_sel,
   input  logic            ctl_alu_x_sel,
   input  logic            ctl_alu_y_sel,
   input  logic [3:0]      ctl_alu_op,
   input  logic [XLEN-1:0] ctl_pc,
   input  logic [XLEN-1:0] ctl_immed,
   input  logic            ctl_mem_start,
   input  logic            ctl_mem_we,
   input  logic            ctl_mem_addr_sel,
   input  logic [1:0]      ctl_mem_width,
   input  logic            ctl_mem_signed,
   output logic            sts_mem_busy,
   output logic            sts_mem_done,
   output logic            sts_misaligned,
   output logic [XLEN-1:0] sts_mdr,
   output logic [XLEN-1:0] sts_alu_w,
   output logic            mem_valid,
   input  logic            mem_ready,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [1:0]      mem_width,
   output logic [XLEN-1:0] mem_wdata,
   input  logic [XLEN-1:0] mem_rdata
);

   localparam int SH_W = $clog2(XLEN);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   state_t                 state, state_nx;
   logic [XLEN-1:0]        regs [NREGS];
   logic [XLEN-1:0]        rs1_d, rs2_d, alu_x, alu_y, wb_d, addr_mux, mdr;
   logic signed [XLEN-1:0] alu_x_s, alu_y_s;
   logic [SH_W-1:0]        shamt;
   logic                   rf_wr, capture, addr_bad, signed_q;

   // Width-selected sign/zero extension of right-justified load data.
   function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] d,
                                                input logic [1:0] w, input logic s);
      logic [XLEN-1:0] r;
      case (w)
         2'd0:    r = s ? XLEN'($signed(d[7:0]))  : XLEN'(d[7:0]);
         2'd1:    r = s ? XLEN'($signed(d[15:0])) : XLEN'(d[15:0]);
         2'd2:    r = s ? XLEN'($signed(d[31:0])) : XLEN'(d[31:0]);
         default: r = (XLEN == 64) ? d : (s ? XLEN'($signed(d[31:0])) : XLEN'(d[31:0]));
      endcase
      return r;
   endfunction

   assign rs1_d   = (ctl_rs1 == '0) ? '0 : regs[ctl_rs1];
   assign rs2_d   = (ctl_rs2 == '0) ? '0 : regs[ctl_rs2];
   assign alu_x   = ctl_alu_x_sel ? ctl_pc : rs1_d;
   assign alu_y   = ctl_alu_y_sel ? ctl_immed : rs2_d;
   assign alu_x_s = alu_x;
   assign alu_y_s = alu_y;
   assign shamt   = alu_y[SH_W-1:0];

   always_comb begin
      sts_alu_w = '0;
      case (ctl_alu_op)
         4'd0:  sts_alu_w = alu_x + alu_y;
         4'd8:  sts_alu_w = alu_x - alu_y;
         4'd1:  sts_alu_w = alu_x << shamt;
         4'd2:  sts_alu_w = (alu_x_s < alu_y_s) ? XLEN'(1) : '0;
         4'd3:  sts_alu_w = (alu_x < alu_y) ? XLEN'(1) : '0;
         4'd4:  sts_alu_w = alu_x ^ alu_y;
         4'd5:  sts_alu_w = alu_x >> shamt;
         4'd13: sts_alu_w = alu_x_s >>> shamt;
         4'd6:  sts_alu_w = alu_x | alu_y;
         4'd7:  sts_alu_w = alu_x & alu_y;
         default: sts_alu_w = '0;
      endcase
   end

   always_comb begin
      wb_d = '0;
      case (ctl_rf_d_sel)
         2'd0:    wb_d = mdr;
         2'd1:    wb_d = sts_alu_w;
         2'd2:    wb_d = ctl_pc + XLEN'(4);
         default: wb_d = '0;
      endcase
   end

   assign rf_wr = ctl_rf_we && (ctl_rd != '0) && (ctl_rf_d_sel != 2'd3);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (rf_wr) begin
         regs[ctl_rd] <= wb_d;
      end
   end

   assign addr_mux = ctl_mem_addr_sel ? ctl_pc : sts_alu_w;

`ifdef DATAPATH_MISALIGN_CHECK_EN
   always_comb begin
      addr_bad = 1'b0;
      case (ctl_mem_width)
         2'd1:    addr_bad = addr_mux[0];
         2'd2:    addr_bad = |addr_mux[1:0];
         2'd3:    addr_bad = |addr_mux[2:0];
         default: addr_bad = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) sts_misaligned <= 1'b0;
      else     sts_misaligned <= (state == IDLE) && ctl_mem_start && addr_bad;
   end
`else
   assign addr_bad       = 1'b0;
   assign sts_misaligned = 1'b0;
`endif

   assign capture = (state == IDLE) && ctl_mem_start && !addr_bad;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (capture) state_nx = REQ;
         REQ:     if (mem_ready) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Request registers are held from capture until the next accepted start.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_width <= '0;
         mem_wdata <= '0;
         signed_q  <= 1'b0;
         mdr       <= '0;
      end else begin
         if (capture) begin
            mem_we    <= ctl_mem_we;
            mem_addr  <= addr_mux;
            mem_width <= ctl_mem_width;
            mem_wdata <= rs2_d;
            signed_q  <= ctl_mem_signed;
         end
         if ((state == REQ) && mem_ready && !mem_we)
            mdr <= load_ext(mem_rdata, mem_width, signed_q);
      end
   end

   assign mem_valid    = (state == REQ);
   assign sts_mem_busy = (state != IDLE);
   assign sts_mem_done = (state == DONE);
   assign sts_mdr      = mdr;

endmodule

// File: tb/tb_datapath_mc.sv
// Self-checking bench for datapath_mc: ALU vector table, random regfile/ALU/load checks
// against a reference model, and directed sequencer corner cases.
module tb_datapath_mc;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;

   logic            clk, rst;
   logic [4:0]      ctl_rs1, ctl_rs2, ctl_rd;
   logic            ctl_rf_we;
   logic [1:0]      ctl_rf_d_sel;
   logic            ctl_alu_x_sel, ctl_alu_y_sel;
   logic [3:0]      ctl_alu_op;
   logic [31:0]     ctl_pc, ctl_immed;
   logic            ctl_mem_start, ctl_mem_we, ctl_mem_addr_sel;
   logic [1:0]      ctl_mem_width;
   logic            ctl_mem_signed;
   logic            sts_mem_busy, sts_mem_done, sts_misaligned;
   logic [31:0]     sts_mdr, sts_alu_w;
   logic            mem_valid, mem_ready, mem_we;
   logic [31:0]     mem_addr, mem_wdata, mem_rdata;
   logic [1:0]      mem_width;

   int n_tests = 0;
   int n_fail  = 0;

   datapath_mc #(.XLEN(XLEN), .NREGS(NREGS)) dut (
      .clk(clk), .rst(rst),
      .ctl_rs1(ctl_rs1), .ctl_rs2(ctl_rs2), .ctl_rd(ctl_rd),
      .ctl_rf_we(ctl_rf_we), .ctl_rf_d_sel(ctl_rf_d_sel),
      .ctl_alu_x_sel(ctl_alu_x_sel), .ctl_alu_y_sel(ctl_alu_y_sel),
      .ctl_alu_op(ctl_alu_op), .ctl_pc(ctl_pc), .ctl_immed(ctl_immed),
      .ctl_mem_start(ctl_mem_start), .ctl_mem_we(ctl_mem_we),
      .ctl_mem_addr_sel(ctl_mem_addr_sel), .ctl_mem_width(ctl_mem_width),
      .ctl_mem_signed(ctl_mem_signed),
      .sts_mem_busy(sts_mem_busy), .sts_mem_done(sts_mem_done),
      .sts_misaligned(sts_misaligned), .sts_mdr(sts_mdr), .sts_alu_w(sts_alu_w),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_width(mem_width), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] exp;
   } alu_vec_t;

   alu_vec_t    alu_tbl [12];
   logic [31:0] mdl [NREGS];
   logic [3:0]  op_list [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_ctl();
      ctl_rs1 = '0; ctl_rs2 = '0; ctl_rd = '0; ctl_rf_we = 1'b0; ctl_rf_d_sel = 2'd1;
      ctl_alu_x_sel = 1'b0; ctl_alu_y_sel = 1'b0; ctl_alu_op = '0;
      ctl_pc = '0; ctl_immed = '0; ctl_mem_start = 1'b0; ctl_mem_we = 1'b0;
      ctl_mem_addr_sel = 1'b0; ctl_mem_width = '0; ctl_mem_signed = 1'b0;
      mem_ready = 1'b0; mem_rdata = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   // Writes val into rd through the ALU path (rs1=x0 + immed).
   task automatic write_reg(input logic [4:0] r, input logic [31:0] val);
      ctl_rs1 = '0; ctl_alu_x_sel = 1'b0; ctl_alu_y_sel = 1'b1; ctl_immed = val;
      ctl_alu_op = 4'd0; ctl_rf_d_sel = 2'd1; ctl_rd = r; ctl_rf_we = 1'b1;
      step();
      ctl_rf_we = 1'b0;
   endtask

   task automatic rd_rs1(input logic [4:0] r, output logic [31:0] v);
      ctl_rf_we = 1'b0; ctl_rs1 = r; ctl_alu_x_sel = 1'b0; ctl_alu_y_sel = 1'b1;
      ctl_immed = '0; ctl_alu_op = 4'd0;
      #1 v = sts_alu_w;
   endtask

   task automatic rd_rs2(input logic [4:0] r, output logic [31:0] v);
      ctl_rf_we = 1'b0; ctl_rs2 = r; ctl_alu_x_sel = 1'b1; ctl_pc = '0;
      ctl_alu_y_sel = 1'b0; ctl_alu_op = 4'd0;
      #1 v = sts_alu_w;
   endtask

   function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] x,
                                           input logic [31:0] y);
      int unsigned sh;
      sh = y % 32;
      case (op)
         4'd0:  return x + y;
         4'd8:  return x - y;
         4'd1:  return x << sh;
         4'd2:  return (int'(x) < int'(y)) ? 32'd1 : 32'd0;
         4'd3:  return (x < y) ? 32'd1 : 32'd0;
         4'd4:  return x ^ y;
         4'd5:  return x >> sh;
         4'd13: return (x >> sh) | (x[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
         4'd6:  return x | y;
         4'd7:  return x & y;
         default: return 32'd0;
      endcase
   endfunction

   // Reference load extension: mask to access size, then subtract 2^bits when negative.
   function automatic logic [31:0] ext_ref(input logic [31:0] d, input logic [1:0] w,
                                           input logic s);
      int          bits;
      logic [63:0] v;
      bits = (w == 2'd0) ? 8 : (w == 2'd1) ? 16 : 32;
      v = {32'd0, d} & ((64'd1 << bits) - 64'd1);
      if (s && v[bits-1]) v = v - (64'd1 << bits);
      return v[31:0];
   endfunction

   // Load with a fixed number of wait states; checks exact cycle-by-cycle latency.
   task automatic do_load(input logic [31:0] addr, input logic [1:0] w, input logic s,
                          input logic [31:0] rdata, input int waits, input logic [31:0] exp);
      ctl_mem_start = 1'b1; ctl_mem_we = 1'b0; ctl_mem_addr_sel = 1'b1; ctl_pc = addr;
      ctl_mem_width = w; ctl_mem_signed = s; mem_rdata = rdata; mem_ready = (waits == 0);
      @(negedge clk);
      chk("ld_start_valid", mem_valid, 1'b0);
      step();
      ctl_mem_start = 1'b0;
      for (int c = 0; c <= waits; c++) begin
         mem_ready = (c == waits);
         @(negedge clk);
         chk("ld_req_valid", mem_valid, 1'b1);
         chk("ld_req_addr", mem_addr, addr);
         chk("ld_req_width", mem_width, w);
         chk("ld_req_we", mem_we, 1'b0);
         chk("ld_req_done", sts_mem_done, 1'b0);
         step();
      end
      mem_ready = 1'b0;
      @(negedge clk);
      chk("ld_done", sts_mem_done, 1'b1);
      chk("ld_done_valid", mem_valid, 1'b0);
      chk("ld_mdr", sts_mdr, exp);
      step();
      @(negedge clk);
      chk("ld_after_done", sts_mem_done, 1'b0);
      chk("ld_after_busy", sts_mem_busy, 1'b0);
      step();
   endtask

   initial begin
      logic [31:0] v, x, y, mdr_prev;
      logic [4:0]  r;
      logic [1:0]  w, dsel;
      logic        s, we;
      int          waits;

      alu_tbl[0]  = '{4'd0,  32'h0000_0005, 32'h0000_0003, 32'h0000_0008};
      alu_tbl[1]  = '{4'd8,  32'h0000_0005, 32'h0000_0003, 32'h0000_0002};
      alu_tbl[2]  = '{4'd8,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
      alu_tbl[3]  = '{4'd0,  32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001};
      alu_tbl[4]  = '{4'd1,  32'h0000_0001, 32'h0000_001F, 32'h8000_0000};
      alu_tbl[5]  = '{4'd2,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
      alu_tbl[6]  = '{4'd3,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
      alu_tbl[7]  = '{4'd4,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0};
      alu_tbl[8]  = '{4'd5,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000};
      alu_tbl[9]  = '{4'd13, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000};
      alu_tbl[10] = '{4'd6,  32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0};
      alu_tbl[11] = '{4'd7,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
      op_list = '{4'd0, 4'd8, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd13, 4'd6, 4'd7};

      idle_ctl();
      rst = 1'b0;
      do_reset();

      // Reset state
      @(negedge clk);
      rd_rs1(5'd0, v);  chk("rst_rs1_0", v, 32'd0);
      rd_rs2(5'd5, v);  chk("rst_rs2_5", v, 32'd0);
      chk("rst_valid", mem_valid, 1'b0);
      chk("rst_busy", sts_mem_busy, 1'b0);
      chk("rst_done", sts_mem_done, 1'b0);
      chk("rst_mis", sts_misaligned, 1'b0);
      chk("rst_mdr", sts_mdr, 32'd0);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      chk("rst_width", mem_width, 2'd0);
      chk("rst_we", mem_we, 1'b0);
      step();

      // Regfile write/read, x0 hardwired
      write_reg(5'd5, 32'h1234_5678);
      rd_rs2(5'd5, v);  chk("rf_rd5", v, 32'h1234_5678);
      write_reg(5'd0, 32'hDEAD_BEEF);
      rd_rs1(5'd0, v);  chk("rf_x0_rs1", v, 32'd0);
      rd_rs2(5'd0, v);  chk("rf_x0_rs2", v, 32'd0);
      step();

      // Same-cycle read returns old value; PC+4 writeback; d_sel=3 never writes
      write_reg(5'd7, 32'h0000_AAAA);
      ctl_rs1 = 5'd7; ctl_alu_x_sel = 1'b0; ctl_alu_y_sel = 1'b1; ctl_immed = '0;
      ctl_alu_op = 4'd0; ctl_rf_d_sel = 2'd2; ctl_pc = 32'hFFFF_FFFE; ctl_rd = 5'd7;
      ctl_rf_we = 1'b1;
      #1 chk("rf_same_cycle_old", sts_alu_w, 32'h0000_AAAA);
      step();
      rd_rs1(5'd7, v);  chk("rf_pc4_wrap", v, 32'h0000_0002);
      ctl_rf_d_sel = 2'd3; ctl_rd = 5'd7; ctl_rf_we = 1'b1;
      step();
      rd_rs1(5'd7, v);  chk("rf_dsel3_nowrite", v, 32'h0000_0002);
      step();

      // ALU vector table
      for (int i = 0; i < 12; i++) begin
         ctl_alu_x_sel = 1'b1; ctl_alu_y_sel = 1'b1;
         ctl_pc = alu_tbl[i].x; ctl_immed = alu_tbl[i].y; ctl_alu_op = alu_tbl[i].op;
         #1 chk($sformatf("alu_tbl%0d", i), sts_alu_w, alu_tbl[i].exp);
      end

      // Random ALU against the reference model
      for (int i = 0; i < 40; i++) begin
         x = $urandom; y = $urandom;
         ctl_alu_op = op_list[$urandom_range(0, 9)];
         ctl_alu_x_sel = 1'b1; ctl_alu_y_sel = 1'b1; ctl_pc = x; ctl_immed = y;
         #1 chk("alu_rand", sts_alu_w, alu_ref(ctl_alu_op, x, y));
      end
      step();

      // Random regfile traffic against an array model
      do_reset();
      for (int i = 0; i < NREGS; i++) mdl[i] = '0;
      for (int i = 0; i < 60; i++) begin
         r = 5'($urandom); v = $urandom; we = 1'($urandom);
         dsel = 2'($urandom_range(1, 3));
         ctl_rs1 = '0; ctl_alu_x_sel = 1'b0; ctl_alu_y_sel = 1'b1; ctl_alu_op = 4'd0;
         ctl_immed = v; ctl_pc = v; ctl_rf_d_sel = dsel; ctl_rd = r; ctl_rf_we = we;
         step();
         if (we && r != 0 && dsel == 2'd1) mdl[r] = v;
         if (we && r != 0 && dsel == 2'd2) mdl[r] = v + 32'd4;
         r = 5'($urandom);
         rd_rs1(r, v);  chk("rf_rand_rs1", v, mdl[r]);
         r = 5'($urandom);
         rd_rs2(r, v);  chk("rf_rand_rs2", v, mdl[r]);
      end
      step();

      // Byte loads, minimum latency, signed and unsigned
      do_load(32'h0000_0100, 2'd0, 1'b1, 32'h0000_0080, 0, 32'hFFFF_FF80);
      do_load(32'h0000_0100, 2'd0, 1'b0, 32'h0000_0080, 0, 32'h0000_0080);

      // MDR writeback source
      ctl_rf_d_sel = 2'd0; ctl_rd = 5'd9; ctl_rf_we = 1'b1;
      step();
      rd_rs1(5'd9, v);  chk("rf_mdr_wb", v, 32'h0000_0080);
      step();

      // Random loads with wait states
      for (int i = 0; i < 20; i++) begin
         w = 2'($urandom); s = 1'($urandom); waits = $urandom_range(0, 3);
         x = $urandom & ~((w == 2'd0) ? 32'd0 : (w == 2'd1) ? 32'd1 :
                          (w == 2'd2) ? 32'd3 : 32'd7);
         y = $urandom;
         do_load(x, w, s, y, waits, ext_ref(y, w, s));
      end
      mdr_prev = sts_mdr;

      // Store word with 3 wait states and an ignored second start
      write_reg(5'd5, 32'h1234_5678);
      ctl_mem_start = 1'b1; ctl_mem_we = 1'b1; ctl_mem_addr_sel = 1'b0; ctl_mem_width = 2'd2;
      ctl_alu_x_sel = 1'b1; ctl_pc = 32'h0000_0200; ctl_alu_y_sel = 1'b1; ctl_immed = '0;
      ctl_alu_op = 4'd0; ctl_rs2 = 5'd5; mem_ready = 1'b0; mem_rdata = 32'hCAFE_F00D;
      step();
      ctl_mem_start = 1'b0;
      for (int c = 0; c < 4; c++) begin
         ctl_mem_start = (c == 1);
         if (c == 1) ctl_pc = 32'h0000_0300;
         mem_ready = (c == 3);
         @(negedge clk);
         chk("st_valid", mem_valid, 1'b1);
         chk("st_addr", mem_addr, 32'h0000_0200);
         chk("st_wdata", mem_wdata, 32'h1234_5678);
         chk("st_we", mem_we, 1'b1);
         chk("st_done_early", sts_mem_done, 1'b0);
         step();
      end
      ctl_mem_start = 1'b0; mem_ready = 1'b0;
      @(negedge clk);
      chk("st_done", sts_mem_done, 1'b1);
      chk("st_mdr_kept", sts_mdr, mdr_prev);
      step();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("st_single_done", sts_mem_done, 1'b0);
         chk("st_no_restart", mem_valid, 1'b0);
         step();
      end

      // Reset during REQ
      ctl_mem_start = 1'b1; ctl_mem_we = 1'b0; ctl_mem_addr_sel = 1'b1; ctl_pc = 32'h400;
      ctl_mem_width = 2'd2; mem_ready = 1'b0;
      step();
      ctl_mem_start = 1'b0;
      @(negedge clk);
      chk("rq_valid", mem_valid, 1'b1);
      rst = 1'b1; mem_ready = 1'b1;
      step();
      rst = 1'b0; mem_ready = 1'b0;
      @(negedge clk);
      chk("rq_rst_valid", mem_valid, 1'b0);
      chk("rq_rst_busy", sts_mem_busy, 1'b0);
      chk("rq_rst_done", sts_mem_done, 1'b0);
      chk("rq_rst_mdr", sts_mdr, 32'd0);
      step();
      @(negedge clk);
      chk("rq_rst_no_done", sts_mem_done, 1'b0);
      step();

      // Misaligned halfword at 0x101
      ctl_mem_start = 1'b1; ctl_mem_we = 1'b0; ctl_mem_addr_sel = 1'b1; ctl_pc = 32'h101;
      ctl_mem_width = 2'd1; ctl_mem_signed = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h55;
      step();
      ctl_mem_start = 1'b0;
      @(negedge clk);
`ifdef DATAPATH_MISALIGN_CHECK_EN
      chk("mis_pulse", sts_misaligned, 1'b1);
      chk("mis_valid", mem_valid, 1'b0);
      chk("mis_busy", sts_mem_busy, 1'b0);
      step();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("mis_pulse_end", sts_misaligned, 1'b0);
         chk("mis_never_valid", mem_valid, 1'b0);
         chk("mis_mdr", sts_mdr, 32'd0);
         step();
      end
`else
      chk("mis_tied0", sts_misaligned, 1'b0);
      chk("mis_off_valid", mem_valid, 1'b1);
      chk("mis_off_addr", mem_addr, 32'h0000_0101);
      step();
      @(negedge clk);
      chk("mis_off_done", sts_mem_done, 1'b1);
      chk("mis_off_mdr", sts_mdr, 32'h0000_0055);
      step();
`endif
      mem_ready = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/datapath_mc.md
Name: datapath_mc

Overview:
- Parametrised multicycle successor to the single-cycle core datapath.
- Adds a registered memory-access sequencer with a valid/ready handshake and wait-state support, a memory data register (MDR), and a third writeback source (PC+4).
- Integrates the register file, ALU muxes, ALU and load extension.
- Generalised in XLEN and register count; sits between the core control FSM and the memory port.

Parameters:
XLEN, 32, datapath width; 32 or 64 only.
NREGS, 32, architectural register count; power of two, at least 2.
RA_W, $clog2(NREGS), register address width (derived, not overridden).

Ports:
clk  in  1  clock.
rst  in  1  reset.
ctl_rs1, ctl_rs2, ctl_rd  in  RA_W each  register addresses.
ctl_rf_we  in  1  regfile write enable.
ctl_rf_d_sel  in  2  writeback source: 0 MDR, 1 ALU, 2 PC+4, 3 reserved (no write).
ctl_alu_x_sel  in  1  ALU x source: 0 rs1, 1 pc.
ctl_alu_y_sel  in  1  ALU y source: 0 rs2, 1 immed.
ctl_alu_op  in  4  ALU operation (existing alu encoding).
ctl_pc, ctl_immed  in  XLEN each  pc and immediate.
ctl_mem_start  in  1  start memory access.
ctl_mem_we  in  1  1 store, 0 load.
ctl_mem_addr_sel  in  1  address source: 0 ALU, 1 pc.
ctl_mem_width  in  2  0 B, 1 H, 2 W, 3 D.
ctl_mem_signed  in  1  sign-extend loads.
sts_mem_busy  out  1  sequencer not IDLE.
sts_mem_done  out  1  one-cycle completion pulse.
sts_misaligned  out  1  misaligned-access pulse (see Optional Feature).
sts_mdr  out  XLEN  MDR contents.
sts_alu_w  out  XLEN  combinational ALU result.
mem_valid  out  1  request valid.
mem_ready  in  1  memory accepts/completes.
mem_we  out  1  request is a write.
mem_addr  out  XLEN  byte address.
mem_width  out  2  access width.
mem_wdata  out  XLEN  store data (rs2, unshifted).
mem_rdata  in  XLEN  load data, right-justified, valid when mem_valid && mem_ready.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - State IDLE.
  - mem_valid, mem_we 0; mem_addr, mem_wdata, mem_width 0.
  - MDR 0.
  - sts_mem_busy, sts_mem_done, sts_misaligned 0.
  - All regfile entries 0.
- Reset mid-access drops mem_valid on the next edge; no MDR update; no done pulse.
- Regfile:
  - Two async read ports, one sync write port.
  - Write at the edge when ctl_rf_we && ctl_rd != 0 && ctl_rf_d_sel != 3.
  - Register 0 always reads 0.
  - Read of a register written this cycle returns the old value.
- Sequencer: IDLE -> REQ -> DONE -> IDLE.
  - IDLE: on ctl_mem_start, capture mux address, rs2, width, we and signed into output registers; go to REQ. mem_valid is 1 from the next cycle.
  - REQ: mem_valid=1; all request outputs held stable until mem_ready.
  - On mem_valid && mem_ready in REQ: load latches the extended mem_rdata into MDR; store leaves MDR unchanged. Go to DONE.
  - DONE: sts_mem_done=1 for exactly one cycle; return to IDLE; mem_valid=0.
  - ctl_mem_start outside IDLE is ignored.
  - Minimum latency with ready held high: start at cycle N, valid at N+1, done at N+2.
  - Each wait state adds one cycle.
- sts_mem_busy = (state != IDLE).
- Load extension (registered-signal based, uses captured width and signed):
  - B uses bits [7:0], H [15:0], W [31:0], D full XLEN.
  - Sign- or zero-extend to XLEN.
  - When XLEN=32, D behaves as W.
- PC+4 writeback: ctl_pc + 4, modulo 2^XLEN.
- ALU operand widths are XLEN; overflow wraps.

Optional Feature:
- Macro: DATAPATH_MISALIGN_CHECK_EN.
- Defined: in IDLE, on ctl_mem_start, if the address is not aligned to the access width (H: addr[0], W: addr[1:0], D: addr[2:0] nonzero):
  - No request is issued and the state stays IDLE.
  - sts_misaligned pulses 1 for one cycle (the cycle after start).
  - MDR is unchanged.
- Undefined: the access is issued as-is and sts_misaligned is tied to 0.

Test Plan:
1. Reset, then read rs1=0 and rs2=5 -> both 0; mem_valid=0; sts_mem_busy=0.
2. Write rd=5 with 0x1234_5678 via d_sel=ALU (x=rs1=0, y=immed, op add); read back rs2=5 -> 0x1234_5678. Write rd=0 -> reads stay 0.
3. Load byte, signed, addr 0x100; mem_ready held high; rdata=0x0000_0080:
   - Valid at N+1; done at N+2.
   - MDR=0xFFFF_FF80.
   - Unsigned repeat gives 0x0000_0080.
4. Store word; mem_ready low for 3 cycles:
   - mem_valid, mem_addr, mem_wdata held stable for 4 cycles.
   - A second ctl_mem_start during REQ is ignored.
   - One done pulse; MDR unchanged.
5. Assert rst during REQ -> mem_valid=0 and state IDLE after the edge; no done pulse.
6. With DATAPATH_MISALIGN_CHECK_EN, halfword at 0x101 -> sts_misaligned=1 for 1 cycle; mem_valid never asserts. Without the macro -> request issued at 0x101.
